// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, FSM states and buffered-entry type for the fetch stage
package fetch_pkg;
    localparam int DEF_XLEN = 64;
    localparam int DEF_ILEN = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = '0;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DROP} fetch_state_t;
    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem request/response, redirect and decode handshake bundle
interface instr_fetch_unit_if import fetch_pkg::*; #(
    parameter int XLEN = DEF_XLEN,
    parameter int ILEN = DEF_ILEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [ILEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;
    modport master (
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
    );
    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two synchronous prefetch queue with push/pop/flush
module fetch_fifo import fetch_pkg::*; #(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    assign full = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout = mem_q[rd_q];
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Storage write and pointer/count update; flush only resets the bookkeeping
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d = flush ? '0 : wr_q + AW'(do_push);
        rd_d = flush ? '0 : rd_q + AW'(do_pop);
        count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end
    // Queue registers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing single-outstanding imem reads into a prefetch FIFO for decode.
// Define FETCH_PERF_CNT_EN to add saturating stall/flush event counters.
module instr_fetch_unit import fetch_pkg::*; #(
    parameter int XLEN = DEF_XLEN,
    parameter int ILEN = DEF_ILEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
    input logic clk,
    input logic reset,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;
    fetch_state_t state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic push, full, empty;
    logic [CW-1:0] count;
    entry_t din, head;
    assign din = {req_pc_q, bus.imem_rdata};
    assign push = state_q == WAIT && bus.imem_rvalid && !bus.redirect_valid;
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (bus.dec_ready),
        .flush (bus.redirect_valid),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign bus.dec_valid = count != '0;
    assign bus.dec_instr = empty ? '0 : head.instr;
    assign bus.dec_pc = empty ? '0 : head.pc;
    assign bus.imem_addr = bus.imem_req ? fetch_pc_q : '0;
    // Next state, PC and request; a redirect overrides all. A redirect that coincides with
    // the pending response has nothing left in flight, so it resumes fetching instead of DROP.
    always_comb begin
        state_d = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d = req_pc_q;
        bus.imem_req = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: if (!full) begin
                bus.imem_req = 1'b1;
                req_pc_d = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                state_d = WAIT;
            end
            WAIT, DROP: if (bus.imem_rvalid) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        if (bus.redirect_valid) begin
            bus.imem_req = 1'b0;
            req_pc_d = req_pc_q;
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            state_d = ((state_q == WAIT || state_q == DROP) && !bus.imem_rvalid) ? DROP : FETCH;
        end
    end
    // FSM and PC registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q <= req_pc_d;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    // Saturating counts of starved decode cycles and redirects that threw work away
    always_comb begin
        stall_cnt_d = (bus.dec_ready && empty && ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        flush_cnt_d = (bus.redirect_valid && (!empty || state_q == WAIT) && ~&flush_cnt_q) ? flush_cnt_q + 32'd1 : flush_cnt_q;
    end
    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a variable-latency memory returning addr>>2
module tb_instr_fetch_unit;
    import fetch_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int mem_lat = 1;
    int mem_cd = 0;
    logic [63:0] mem_pend = '0;
    fetch_entry_t exp_q[$];
    logic [63:0] req_log[$];
    instr_fetch_unit_if bus ();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
    instr_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [63:0] pc);
        fetch_entry_t e;
        e.pc = pc;
        e.instr = pc[33:2];
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc();
        check({"drain_", tag}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        bus.dec_ready = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = pc;
        #1;
        check("no_req_on_redirect", 64'(bus.imem_req), 64'd0);
        cyc();
        bus.redirect_valid = 1'b0;
    endtask

    // Memory model and decode-side scoreboard, evaluated mid-cycle
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            if (mem_cd > 0) begin
                mem_cd--;
                if (mem_cd == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata = mem_pend[33:2];
                end
            end
            if (bus.imem_req) begin
                mem_pend = bus.imem_addr;
                mem_cd = mem_lat;
                req_log.push_back(bus.imem_addr);
            end
            if (!reset && !bus.redirect_valid && bus.dec_valid && bus.dec_ready) begin
                check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    fetch_entry_t e;
                    e = exp_q.pop_front();
                    check("dec_pc", bus.dec_pc, e.pc);
                    check("dec_instr", 64'(bus.dec_instr), 64'(e.instr));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int snap;
        bit found;
        bus.dec_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (3) cyc();
        check("rst_imem_req", 64'(bus.imem_req), 64'd0);
        check("rst_imem_addr", bus.imem_addr, 64'd0);
        check("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
        check("rst_dec_instr", 64'(bus.dec_instr), 64'd0);
        check("rst_dec_pc", bus.dec_pc, 64'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);
        check("rst_flush_cnt", 64'(perf_flush_cnt), 64'd0);
`endif
        // Sequential fetch with 1-cycle memory
        for (int i = 0; i < 4; i++) expect_pc(64'(i * 4));
        reset = 1'b0;
        bus.dec_ready = 1'b1;
        lat = 0;
        while (!bus.dec_valid && lat < 10) begin
            cyc();
            lat++;
        end
        check("first_valid_latency", 64'(lat), 64'd3);
        drain("seq");
        bus.dec_ready = 1'b0;
        // Backpressure fills the FIFO, then drains in order
        do_reset();
        snap = req_log.size();
        repeat (20) cyc();
        check("req_count_full", 64'(req_log.size() - snap), 64'd4);
        check("req_low_full", 64'(bus.imem_req), 64'd0);
        check("valid_full", 64'(bus.dec_valid), 64'd1);
        for (int i = 0; i < 5; i++) expect_pc(64'(i * 4));
        bus.dec_ready = 1'b1;
        drain("full");
        bus.dec_ready = 1'b0;
        // Redirect while waiting on the 0x8 response (slow memory, so it lands in DROP)
        do_reset();
        mem_lat = 3;
        snap = req_log.size();
        expect_pc(64'h0);
        expect_pc(64'h4);
        expect_pc(64'h100);
        expect_pc(64'h104);
        bus.dec_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc();
            found = req_log.size() > snap && req_log[$] == 64'h8;
        end
        check("saw_req_8", 64'(found), 64'd1);
        redirect(64'h100);
        drain("redirect");
        bus.dec_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check("flush_cnt_one", 64'(perf_flush_cnt), 64'd1);
`endif
        // Misaligned redirect target is forced to word alignment
        mem_lat = 1;
        snap = req_log.size();
        expect_pc(64'h100);
        expect_pc(64'h104);
        redirect(64'h103);
        for (int i = 0; i < 20 && req_log.size() <= snap; i++) cyc();
        check("align_req_seen", 64'(req_log.size() > snap), 64'd1);
        if (req_log.size() > snap) check("align_imem_addr", req_log[snap], 64'h100);
        bus.dec_ready = 1'b1;
        drain("align");
        bus.dec_ready = 1'b0;
        // PC wraps from the top of the address space
        snap = req_log.size();
        expect_pc(64'hFFFF_FFFF_FFFF_FFFC);
        expect_pc(64'h0);
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        bus.dec_ready = 1'b1;
        drain("wrap");
        bus.dec_ready = 1'b0;
        check("wrap_req_seen", 64'(req_log.size() >= snap + 2), 64'd1);
        if (req_log.size() >= snap + 2) begin
            check("wrap_first_addr", req_log[snap], 64'hFFFF_FFFF_FFFF_FFFC);
            check("wrap_second_addr", req_log[snap+1], 64'h0);
        end
        // Reset mid-WAIT; the late response must be ignored
        mem_lat = 3;
        redirect(64'h40);
        check("flush_dec_valid", 64'(bus.dec_valid), 64'd0);
        check("flush_dec_pc", bus.dec_pc, 64'd0);
        snap = req_log.size();
        for (int i = 0; i < 20 && req_log.size() <= snap; i++) cyc();
        check("mid_req_seen", 64'(req_log.size() > snap), 64'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_q.delete();
`ifdef FETCH_PERF_CNT_EN
        check("mid_rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);
        check("mid_rst_flush_cnt", 64'(perf_flush_cnt), 64'd0);
`endif
        expect_pc(64'(DEF_RESET_PC));
        bus.dec_ready = 1'b1;
        drain("reset_mid");
        bus.dec_ready = 1'b0;
        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
